// File: rtl/bean_wb_arbiter.sv
// -----------------------------------------------------------------------------
// bean_wb_arbiter
//
// Write-back arbiter for the two rd write channels of the BEAN register file.
// Each of N_SRC execution units hands its results over a valid/ready handshake
// into a small private FIFO. Every cycle a round-robin scan over the FIFO heads
// grants up to two entries, one per rd channel, and the granted entries are
// turned into registered register-file writes one cycle later.
//
// Select words are 7 bits: [6:5] bank (0=X, 1=F, 2=I, 3=illegal), [4:0] index.
//
// Ports
//   clk        in   core clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   src_valid  in   [N_SRC]        per-source result valid
//   src_ready  out  [N_SRC]        per-source FIFO can accept (0 during reset)
//   src_sel    in   [N_SRC*SEL_W]  per-source destination select, source s at [s*SEL_W +: SEL_W]
//   src_data   in   [N_SRC*XLEN]   per-source result data, source s at [s*XLEN +: XLEN]
//   wr_en      out  [2]            write strobe per rd channel
//   wr_sel     out  [2*SEL_W]      select per channel, channel c at [c*SEL_W +: SEL_W]
//   wr_data    out  [2*XLEN]       data per channel, channel c at [c*XLEN +: XLEN]
//   busy       out                 any FIFO non-empty or any write strobe set
//   error      out                 sticky: an illegal-bank result was received
// -----------------------------------------------------------------------------
module bean_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int SEL_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*SEL_W-1:0]  src_sel,
    input  logic [N_SRC*XLEN-1:0]   src_data,
    output logic [1:0]              wr_en,
    output logic [2*SEL_W-1:0]      wr_sel,
    output logic [2*XLEN-1:0]       wr_data,
    output logic                    busy,
    output logic                    error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       BANK_ILL = 2'd3;

    // ---------------------------------------------------------------------
    // Per-source FIFOs
    // ---------------------------------------------------------------------
    logic [N_SRC-1:0] head_vld;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic [SEL_W-1:0] head_sel  [N_SRC];
    logic [XLEN-1:0]  head_data [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
            logic [SEL_W-1:0] sel_mem  [FIFO_DEPTH];
            logic [XLEN-1:0]  data_mem [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [CNT_W-1:0] count_q;

            // Ready looks only at the stored count, so a full FIFO refuses a
            // push even when it is popped in the same cycle. Gating with rst_n
            // keeps ready low for the whole reset assertion.
            assign src_ready[gi] = rst_n && (count_q != CNT_FULL);
            assign push[gi]      = src_valid[gi] && src_ready[gi];
            assign head_vld[gi]  = (count_q != '0);
            assign head_sel[gi]  = sel_mem[rd_ptr_q];
            assign head_data[gi] = data_mem[rd_ptr_q];

            // Storage carries no reset; validity is tracked by count_q.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    sel_mem[wr_ptr_q]  <= src_sel[gi*SEL_W +: SEL_W];
                    data_mem[wr_ptr_q] <= src_data[gi*XLEN +: XLEN];
                end
            end

            // Depth is a power of two, so the pointers wrap naturally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_q <= count_q + 1'b1;
                        2'b01:   count_q <= count_q - 1'b1;
                        default: count_q <= count_q;
                    endcase
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Round-robin arbitration over the FIFO heads
    // ---------------------------------------------------------------------
    logic [RR_W-1:0]  rr_q;
    logic [RR_W-1:0]  rr_d;
    logic [1:0]       gnt_vld;
    logic [RR_W-1:0]  gnt_src  [2];
    logic [SEL_W-1:0] gnt_sel  [2];
    logic [XLEN-1:0]  gnt_data [2];
    logic [RR_W:0]    arb_sum;
    logic [RR_W-1:0]  arb_idx;
    logic [RR_W-1:0]  last_src;

    always_comb begin
        gnt_vld  = '0;
        pop      = '0;
        arb_sum  = '0;
        arb_idx  = '0;
        last_src = '0;
        rr_d     = rr_q;
        for (int c = 0; c < 2; c++) begin
            gnt_src[c]  = '0;
            gnt_sel[c]  = '0;
            gnt_data[c] = '0;
        end

        for (int k = 0; k < N_SRC; k++) begin
            // Source index (rr_q + k) mod N_SRC without a divider.
            arb_sum = {1'b0, rr_q} + (RR_W+1)'(k);
            if (arb_sum >= (RR_W+1)'(N_SRC)) begin
                arb_sum = arb_sum - (RR_W+1)'(N_SRC);
            end
            arb_idx = arb_sum[RR_W-1:0];

            if (head_vld[arb_idx]) begin
                if (!gnt_vld[0]) begin
                    gnt_vld[0]    = 1'b1;
                    gnt_src[0]    = arb_idx;
                    gnt_sel[0]    = head_sel[arb_idx];
                    gnt_data[0]   = head_data[arb_idx];
                    pop[arb_idx]  = 1'b1;
                end else if (!gnt_vld[1] && (head_sel[arb_idx] != gnt_sel[0])) begin
                    // A head aimed at slot 0's register waits a cycle so the
                    // two channels never write the same register together.
                    gnt_vld[1]    = 1'b1;
                    gnt_src[1]    = arb_idx;
                    gnt_sel[1]    = head_sel[arb_idx];
                    gnt_data[1]   = head_data[arb_idx];
                    pop[arb_idx]  = 1'b1;
                end
            end
        end

        if (gnt_vld[0]) begin
            last_src = gnt_vld[1] ? gnt_src[1] : gnt_src[0];
            rr_d     = (last_src == RR_W'(N_SRC - 1)) ? '0 : last_src + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Write generation
    // ---------------------------------------------------------------------
    logic [1:0]         wr_en_q,   wr_en_d;
    logic [2*SEL_W-1:0] wr_sel_q,  wr_sel_d;
    logic [2*XLEN-1:0]  wr_data_q, wr_data_d;
    logic               error_q,   error_d;

    always_comb begin
        wr_en_d   = '0;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        error_d   = error_q;
        for (int c = 0; c < 2; c++) begin
            if (gnt_vld[c]) begin
                wr_sel_d[c*SEL_W +: SEL_W] = gnt_sel[c];
                wr_data_d[c*XLEN +: XLEN]  = gnt_data[c];
                // x0 and illegal-bank entries still consume the slot but
                // never strobe the register file.
                if (gnt_sel[c][SEL_W-1 -: 2] == BANK_ILL) begin
                    error_d = 1'b1;
                end else if (gnt_sel[c] != '0) begin
                    wr_en_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            wr_en_q   <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            error_q   <= error_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;
    assign error   = error_q;
    assign busy    = (|head_vld) || (|wr_en_q);

endmodule

// File: tb/tb_bean_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bean_wb_arbiter
//
// Scoreboard bench for bean_wb_arbiter. A queue-based reference model samples
// the source handshakes at every rising edge, applies the arbitration rules to
// per-source queues and pushes each expected register write (tagged with the
// cycle it must appear in) into a scoreboard queue. A monitor on the falling
// edge pops and compares every write the DUT presents, and also compares
// src_ready, busy and error against the model every cycle. Directed sequences
// cover the listed scenarios; randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_bean_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int N_SRC = 3;
    localparam int DEPTH = 2;
    localparam int SEL_W = 7;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC-1:0]       src_ready;
    logic [N_SRC*SEL_W-1:0] src_sel;
    logic [N_SRC*XLEN-1:0]  src_data;
    logic [1:0]             wr_en;
    logic [2*SEL_W-1:0]     wr_sel;
    logic [2*XLEN-1:0]      wr_data;
    logic                   busy;
    logic                   error;

    always #5 clk = ~clk;

    bean_wb_arbiter #(
        .XLEN       (XLEN),
        .N_SRC      (N_SRC),
        .FIFO_DEPTH (DEPTH),
        .SEL_W      (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_sel   (src_sel),
        .src_data  (src_data),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .busy      (busy),
        .error     (error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model and scoreboard
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  data;
    } ent_t;

    typedef struct {
        int               cyc;
        int               ch;
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  data;
    } exp_t;

    ent_t mq [N_SRC][$];
    exp_t expq[$];
    int   rr_m   = 0;
    bit   err_m  = 1'b0;
    int   cyc    = 0;
    int   cur_wr = 0;

    always @(posedge clk) begin
        bit               rdy [N_SRC];
        int               ng;
        int               last;
        int               s;
        logic [SEL_W-1:0] s0sel;
        ent_t             e;
        exp_t             x;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) mq[i].delete();
            expq.delete();
            rr_m   = 0;
            err_m  = 1'b0;
            cur_wr = 0;
        end else begin
            for (int i = 0; i < N_SRC; i++) rdy[i] = (mq[i].size() < DEPTH);
            ng     = 0;
            last   = -1;
            cur_wr = 0;
            s0sel  = '0;
            for (int k = 0; k < N_SRC; k++) begin
                s = (rr_m + k) % N_SRC;
                if (ng < 2 && mq[s].size() > 0) begin
                    e = mq[s][0];
                    if (!(ng == 1 && e.sel == s0sel)) begin
                        void'(mq[s].pop_front());
                        if (ng == 0) s0sel = e.sel;
                        if (e.sel[SEL_W-1 -: 2] == 2'd3) begin
                            err_m = 1'b1;
                        end else if (e.sel != '0) begin
                            x.cyc  = cyc;
                            x.ch   = ng;
                            x.sel  = e.sel;
                            x.data = e.data;
                            expq.push_back(x);
                            cur_wr++;
                        end
                        ng++;
                        last = s;
                    end
                end
            end
            if (last >= 0) rr_m = (last + 1) % N_SRC;
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    e.sel  = src_sel[i*SEL_W +: SEL_W];
                    e.data = src_data[i*XLEN +: XLEN];
                    mq[i].push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        int   n_exp;
        bit   busy_m;
        if (rst_n) begin
            n_exp = 0;
            foreach (expq[i]) if (expq[i].cyc == cyc) n_exp++;
            chk_eq("wr_count", 64'($countones(wr_en)), 64'(n_exp));
            for (int c = 0; c < 2; c++) begin
                if (wr_en[c] && expq.size() > 0 && expq[0].cyc == cyc) begin
                    x = expq.pop_front();
                    chk_eq("wr_channel", 64'(c), 64'(x.ch));
                    chk_eq("wr_sel", 64'(wr_sel[c*SEL_W +: SEL_W]), 64'(x.sel));
                    chk_eq("wr_data", 64'(wr_data[c*XLEN +: XLEN]), 64'(x.data));
                    $display("WR cyc=%0d ch=%0d sel=%02h data=%08h", cyc, c,
                             wr_sel[c*SEL_W +: SEL_W], wr_data[c*XLEN +: XLEN]);
                end
            end
            while (expq.size() > 0 && expq[0].cyc <= cyc) void'(expq.pop_front());
            if (wr_en == 2'b11) begin
                chk_eq("no_same_reg", 64'(wr_sel[SEL_W-1:0] == wr_sel[2*SEL_W-1:SEL_W]), 64'd0);
            end
            busy_m = (cur_wr > 0);
            for (int i = 0; i < N_SRC; i++) begin
                chk_eq("src_ready", 64'(src_ready[i]), 64'(mq[i].size() < DEPTH));
                if (mq[i].size() > 0) busy_m = 1'b1;
            end
            chk_eq("busy", 64'(busy), 64'(busy_m));
            chk_eq("error", 64'(error), 64'(err_m));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    task automatic set_src(input int s, input logic v, input logic [SEL_W-1:0] sel,
                           input logic [XLEN-1:0] d);
        src_valid[s]              = v;
        src_sel[s*SEL_W +: SEL_W] = sel;
        src_data[s*XLEN +: XLEN]  = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_wr_en", 64'(wr_en), 64'd0);
        chk_eq("rst_wr_sel", 64'(wr_sel), 64'd0);
        chk_eq("rst_wr_data", 64'(wr_data), 64'd0);
        chk_eq("rst_error", 64'(error), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_src_ready", 64'(src_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_eq("release_src_ready", 64'(src_ready), 64'h7);
    endtask

    task automatic rand_cycle(input int pct);
        logic [1:0] bank;
        logic [4:0] idx;
        for (int s = 0; s < N_SRC; s++) begin
            bank = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            idx  = 5'($urandom_range(0, 3));
            set_src(s, ($urandom_range(0, 99) < pct), {bank, idx}, $urandom);
        end
        tick();
    endtask

    // Runaway guard.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        int  n2;
        bit  acc;
        bit  bp_checked;
        bit  drained;

        rst_n     = 1'b0;
        src_valid = '0;
        src_sel   = '0;
        src_data  = '0;
        tick();
        do_reset();

        // Single write from src0.
        set_src(0, 1'b1, 7'h05, 32'hDEADBEEF);
        tick();
        idle();
        chk_eq("single_t1_wr_en", 64'(wr_en), 64'd0);
        tick();
        chk_eq("single_wr_en", 64'(wr_en), 64'h1);
        chk_eq("single_wr_sel", 64'(wr_sel[6:0]), 64'h05);
        chk_eq("single_wr_data", 64'(wr_data[31:0]), 64'hDEADBEEF);
        tick();
        chk_eq("single_busy_after", 64'(busy), 64'd0);

        // Dual issue and round-robin from rr=0.
        do_reset();
        set_src(0, 1'b1, 7'h01, 32'hA0A0_0001);
        set_src(1, 1'b1, 7'h22, 32'hB1B1_0002);
        set_src(2, 1'b1, 7'h43, 32'hC2C2_0003);
        tick();
        idle();
        tick();
        chk_eq("dual_wr_en", 64'(wr_en), 64'h3);
        chk_eq("dual_sel0", 64'(wr_sel[6:0]), 64'h01);
        chk_eq("dual_sel1", 64'(wr_sel[13:7]), 64'h22);
        chk_eq("dual_data0", 64'(wr_data[31:0]), 64'hA0A0_0001);
        chk_eq("dual_data1", 64'(wr_data[63:32]), 64'hB1B1_0002);
        tick();
        chk_eq("dual2_wr_en", 64'(wr_en), 64'h1);
        chk_eq("dual2_sel0", 64'(wr_sel[6:0]), 64'h43);
        chk_eq("dual2_data0", 64'(wr_data[31:0]), 64'hC2C2_0003);

        // Same-register conflict; rr is back at 0 so src0 wins.
        set_src(0, 1'b1, 7'h07, 32'h0000_7A7A);
        set_src(1, 1'b1, 7'h07, 32'h0000_7B7B);
        tick();
        idle();
        tick();
        chk_eq("conf_wr_en", 64'(wr_en), 64'h1);
        chk_eq("conf_sel0", 64'(wr_sel[6:0]), 64'h07);
        chk_eq("conf_data0", 64'(wr_data[31:0]), 64'h0000_7A7A);
        tick();
        chk_eq("conf2_wr_en", 64'(wr_en), 64'h1);
        chk_eq("conf2_data0", 64'(wr_data[31:0]), 64'h0000_7B7B);
        tick();

        // x0 then illegal bank from src1.
        set_src(1, 1'b1, 7'h00, 32'h1111_1111);
        tick();
        set_src(1, 1'b1, 7'h65, 32'h2222_2222);
        tick();
        idle();
        chk_eq("x0_wr_en", 64'(wr_en), 64'd0);
        chk_eq("x0_error", 64'(error), 64'd0);
        tick();
        chk_eq("ill_wr_en", 64'(wr_en), 64'd0);
        chk_eq("ill_error", 64'(error), 64'd1);
        tick();
        tick();
        chk_eq("ill_error_sticky", 64'(error), 64'd1);
        chk_eq("ill_busy", 64'(busy), 64'd0);

        // Backpressure on src2: all three sources fight for X7.
        do_reset();
        n2         = 0;
        bp_checked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 5) begin
                set_src(0, 1'b1, 7'h07, $urandom);
                set_src(1, 1'b1, 7'h07, $urandom);
            end else begin
                src_valid[0] = 1'b0;
                src_valid[1] = 1'b0;
            end
            if (n2 < 3) set_src(2, 1'b1, 7'h07, 32'h2000_0000 + 32'(n2));
            else        src_valid[2] = 1'b0;
            acc = src_valid[2] && src_ready[2];
            tick();
            if (acc) n2++;
            if (n2 == 2 && !bp_checked) begin
                chk_eq("bp_ready2_low", 64'(src_ready[2]), 64'd0);
                bp_checked = 1'b1;
            end
        end
        idle();
        chk_eq("bp_accepted", 64'(n2), 64'd3);

        // Randomized traffic, then a reset while FIFOs hold data.
        for (int i = 0; i < 300; i++) rand_cycle(70);
        do_reset();
        for (int i = 0; i < 300; i++) rand_cycle(50);

        // Drain.
        idle();
        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            tick();
            drained = (expq.size() == 0) && (mq[0].size() == 0) &&
                      (mq[1].size() == 0) && (mq[2].size() == 0);
        end
        chk_eq("drain_done", 64'(drained), 64'd1);
        tick();
        chk_eq("drain_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
